depacketizer: RTL and testbench

Receive-side parser for the 9-bit packet stream built by the camera packetizer: `{flag, byte}` words, where `flag=1` marks a packet byte and `flag=0` marks a terminator. It finds the fixed sync header and decodes the type byte: 0xFF for camera data, 0x00 for control/status. It then emits payload bytes with start/end markers, packet length, and error flags. It sits after the PC-link receive FIFO in the loopback/bring-up path and feeds the frame-capture or status logic.

---
 rtl/depacketizer.sv | 233 +++++++++++++++++++++++
 tb/tb_depacketizer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/depacketizer.sv
// Receive-side parser for the flagged 9-bit camera packet stream: finds the sync header,
// decodes the packet type and emits payload bytes with sop/eop markers, length and errors.
module depacketizer #(
    parameter int unsigned MAX_LEN = 1023,
    parameter int unsigned LEN_W   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [8:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sop,
    output logic             out_eop,
    output logic             out_is_ctrl,
    output logic [7:0]       ctrl_status,
    output logic             pkt_done,
    output logic [LEN_W-1:0] pkt_len,
    output logic             hdr_err,
    output logic             len_err
);

    typedef enum logic [1:0] {StHunt, StHdr, StType, StPay} state_e;

    state_e           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             hold_sop_q, hold_sop_d;
    logic             is_ctrl_q, is_ctrl_d;
    logic             drop_q, drop_d;
    logic [7:0]       out_byte_q, out_byte_d;
    logic             out_valid_q, out_valid_d;
    logic             out_sop_q, out_sop_d;
    logic             out_eop_q, out_eop_d;
    logic             out_is_ctrl_q, out_is_ctrl_d;
    logic [7:0]       ctrl_status_q, ctrl_status_d;
    logic             pkt_done_q, pkt_done_d;
    logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
    logic             hdr_err_q, hdr_err_d;
    logic             len_err_q, len_err_d;

    logic       accept;
    logic       flag;
    logic [7:0] data;

    function automatic logic [7:0] hdr_byte(input logic [3:0] i);
        logic [7:0] b;
        case (i)
            4'd0:    b = 8'h0A;
            4'd1:    b = 8'h01;
            4'd2:    b = 8'h02;
            4'd3:    b = 8'h03;
            4'd4:    b = 8'h04;
            4'd5:    b = 8'h05;
            4'd6:    b = 8'h0A;
            4'd7:    b = 8'h01;
            4'd8:    b = 8'h02;
            4'd9:    b = 8'h03;
            4'd10:   b = 8'h04;
            4'd11:   b = 8'hCC;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // The hold register drains only on a new accepted word, so readiness hinges on the
    // output register alone.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign flag     = in_data[8];
    assign data     = in_data[7:0];

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        count_d       = count_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        hold_sop_d    = hold_sop_q;
        is_ctrl_d     = is_ctrl_q;
        drop_d        = drop_q;
        out_byte_d    = out_byte_q;
        out_valid_d   = out_valid_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        out_is_ctrl_d = out_is_ctrl_q;
        ctrl_status_d = ctrl_status_q;
        pkt_done_d    = 1'b0;
        pkt_len_d     = pkt_len_q;
        hdr_err_d     = 1'b0;
        len_err_d     = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            unique case (state_q)
                StHunt: begin
                    if (flag && data == 8'h0A) begin
                        state_d = StHdr;
                        idx_d   = 4'd1;
                    end
                end
                StHdr: begin
                    if (flag && data == hdr_byte(idx_q)) begin
                        if (idx_q == 4'd11) begin
                            state_d = StType;
                            idx_d   = 4'd0;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end else begin
                        hdr_err_d = 1'b1;
                        // A stray 0A may itself be the start of a fresh header.
                        if (flag && data == 8'h0A) begin
                            idx_d = 4'd1;
                        end else begin
                            state_d = StHunt;
                            idx_d   = 4'd0;
                        end
                    end
                end
                StType: begin
                    if (flag && (data == 8'hFF || data == 8'h00)) begin
                        is_ctrl_d = (data == 8'h00);
                        state_d   = StPay;
                        count_d   = '0;
                        drop_d    = 1'b0;
                    end else begin
                        hdr_err_d = 1'b1;
                        state_d   = StHunt;
                    end
                end
                StPay: begin
                    if (flag) begin
                        if (count_q < LEN_W'(MAX_LEN)) begin
                            if (hold_full_q) begin
                                out_valid_d   = 1'b1;
                                out_byte_d    = hold_q;
                                out_sop_d     = hold_sop_q;
                                out_eop_d     = 1'b0;
                                out_is_ctrl_d = is_ctrl_q;
                            end
                            hold_d      = data;
                            hold_full_d = 1'b1;
                            hold_sop_d  = (count_q == '0);
                            if (is_ctrl_q && count_q == '0) begin
                                ctrl_status_d = data;
                            end
                            count_d = count_q + LEN_W'(1);
                        end else if (!drop_q) begin
                            len_err_d = 1'b1;
                            drop_d    = 1'b1;
                        end
                    end else begin
                        if (hold_full_q) begin
                            out_valid_d   = 1'b1;
                            out_byte_d    = hold_q;
                            out_sop_d     = hold_sop_q;
                            out_eop_d     = 1'b1;
                            out_is_ctrl_d = is_ctrl_q;
                        end
                        hold_full_d = 1'b0;
                        pkt_done_d  = 1'b1;
                        pkt_len_d   = count_q;
                        count_d     = '0;
                        state_d     = StHunt;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StHunt;
            idx_q         <= 4'd0;
            count_q       <= '0;
            hold_q        <= 8'h00;
            hold_full_q   <= 1'b0;
            hold_sop_q    <= 1'b0;
            is_ctrl_q     <= 1'b0;
            drop_q        <= 1'b0;
            out_byte_q    <= 8'h00;
            out_valid_q   <= 1'b0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            out_is_ctrl_q <= 1'b0;
            ctrl_status_q <= 8'h00;
            pkt_done_q    <= 1'b0;
            pkt_len_q     <= '0;
            hdr_err_q     <= 1'b0;
            len_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            count_q       <= count_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            hold_sop_q    <= hold_sop_d;
            is_ctrl_q     <= is_ctrl_d;
            drop_q        <= drop_d;
            out_byte_q    <= out_byte_d;
            out_valid_q   <= out_valid_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            out_is_ctrl_q <= out_is_ctrl_d;
            ctrl_status_q <= ctrl_status_d;
            pkt_done_q    <= pkt_done_d;
            pkt_len_q     <= pkt_len_d;
            hdr_err_q     <= hdr_err_d;
            len_err_q     <= len_err_d;
        end
    end

    assign out_byte    = out_byte_q;
    assign out_valid   = out_valid_q;
    assign out_sop     = out_sop_q;
    assign out_eop     = out_eop_q;
    assign out_is_ctrl = out_is_ctrl_q;
    assign ctrl_status = ctrl_status_q;
    assign pkt_done    = pkt_done_q;
    assign pkt_len     = pkt_len_q;
    assign hdr_err     = hdr_err_q;
    assign len_err     = len_err_q;

endmodule

// File: tb/tb_depacketizer.sv
// Directed bench for depacketizer: a default instance plus a MAX_LEN=4 instance for
// truncation, all driven and observed from one sequential process.
module tb_depacketizer;

    logic       clk;
    logic       rst;
    logic [8:0] in_data;
    logic       in_valid;
    logic       out_ready;
    logic       use_small;

    logic        m_in_ready, m_out_valid, m_out_sop, m_out_eop, m_out_is_ctrl;
    logic        m_pkt_done, m_hdr_err, m_len_err;
    logic [7:0]  m_out_byte, m_ctrl_status;
    logic [10:0] m_pkt_len;
    logic        s_in_ready, s_out_valid, s_out_sop, s_out_eop, s_out_is_ctrl;
    logic        s_pkt_done, s_hdr_err, s_len_err;
    logic [7:0]  s_out_byte, s_ctrl_status;
    logic [2:0]  s_pkt_len;

    depacketizer dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(m_in_ready),
        .out_byte(m_out_byte), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_sop(m_out_sop), .out_eop(m_out_eop), .out_is_ctrl(m_out_is_ctrl),
        .ctrl_status(m_ctrl_status), .pkt_done(m_pkt_done), .pkt_len(m_pkt_len),
        .hdr_err(m_hdr_err), .len_err(m_len_err)
    );

    depacketizer #(.MAX_LEN(4), .LEN_W(3)) dut_small (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready),
        .out_byte(s_out_byte), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_sop(s_out_sop), .out_eop(s_out_eop), .out_is_ctrl(s_out_is_ctrl),
        .ctrl_status(s_ctrl_status), .pkt_done(s_pkt_done), .pkt_len(s_pkt_len),
        .hdr_err(s_hdr_err), .len_err(s_len_err)
    );

    logic        mo_in_ready, mo_valid, mo_sop, mo_eop, mo_ctrl, mo_done, mo_herr, mo_lerr;
    logic [7:0]  mo_byte, mo_status;
    logic [10:0] mo_len;

    assign mo_in_ready = use_small ? s_in_ready    : m_in_ready;
    assign mo_valid    = use_small ? s_out_valid   : m_out_valid;
    assign mo_sop      = use_small ? s_out_sop     : m_out_sop;
    assign mo_eop      = use_small ? s_out_eop     : m_out_eop;
    assign mo_ctrl     = use_small ? s_out_is_ctrl : m_out_is_ctrl;
    assign mo_done     = use_small ? s_pkt_done    : m_pkt_done;
    assign mo_herr     = use_small ? s_hdr_err     : m_hdr_err;
    assign mo_lerr     = use_small ? s_len_err     : m_len_err;
    assign mo_byte     = use_small ? s_out_byte    : m_out_byte;
    assign mo_status   = use_small ? s_ctrl_status : m_ctrl_status;
    assign mo_len      = use_small ? 11'(s_pkt_len) : m_pkt_len;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec;
    int unsigned n_err;
    logic [10:0] got_q[$];
    logic [10:0] exp_q[$];
    int unsigned done_cnt, hdr_cnt, len_cnt;
    logic [10:0] last_len;
    logic        done_eop;
    logic        last_acc;
    logic        bp_en, bp_chk, prev_stall;
    logic [11:0] prev_out;
    logic [7:0]  hdr [12] = '{8'h0A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                              8'h0A, 8'h01, 8'h02, 8'h03, 8'h04, 8'hCC};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: observe at the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        last_acc = in_valid && mo_in_ready;
        if (rst) begin
            if (mo_valid && out_ready) got_q.push_back({mo_ctrl, mo_sop, mo_eop, mo_byte});
            if (mo_done) begin
                done_cnt++;
                last_len = mo_len;
                done_eop = mo_valid && mo_eop;
            end
            if (mo_herr) hdr_cnt++;
            if (mo_lerr) len_cnt++;
            if (bp_chk) begin
                check("in_ready_bp", 32'(mo_in_ready), 32'(!mo_valid || out_ready));
                if (prev_stall)
                    check("stall_stable", {mo_valid, mo_ctrl, mo_sop, mo_eop, mo_byte},
                          prev_out);
                prev_stall = mo_valid && !out_ready;
                prev_out   = {mo_valid, mo_ctrl, mo_sop, mo_eop, mo_byte};
            end
        end
        @(posedge clk);
        #1;
        if (bp_en) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [8:0] w);
        int n;
        in_data  = w;
        in_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 1000);
        if (!last_acc) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_hdr();
        for (int i = 0; i < 12; i++) send({1'b1, hdr[i]});
    endtask

    task automatic clr();
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
        hdr_cnt  = 0;
        len_cnt  = 0;
        last_len = '0;
        done_eop = 1'b0;
    endtask

    task automatic expect_b(input logic c, input logic s, input logic e, input logic [7:0] b);
        exp_q.push_back({c, s, e, b});
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check(tag, 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, 32'(mo_in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(mo_valid), 32'd0);
        check({tag, "_out_byte"}, 32'(mo_byte), 32'd0);
        check({tag, "_out_sop"}, 32'(mo_sop), 32'd0);
        check({tag, "_out_eop"}, 32'(mo_eop), 32'd0);
        check({tag, "_out_is_ctrl"}, 32'(mo_ctrl), 32'd0);
        check({tag, "_ctrl_status"}, 32'(mo_status), 32'd0);
        check({tag, "_pkt_done"}, 32'(mo_done), 32'd0);
        check({tag, "_pkt_len"}, 32'(mo_len), 32'd0);
        check({tag, "_hdr_err"}, 32'(mo_herr), 32'd0);
        check({tag, "_len_err"}, 32'(mo_lerr), 32'd0);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; use_small = 1'b0;
        bp_en = 1'b0; bp_chk = 1'b0; prev_stall = 1'b0; prev_out = '0; last_acc = 1'b0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b1;

        // Data packet
        send_hdr(); send(9'h1FF); send(9'h10E); send(9'h1AB); send(9'h1CD); send(9'h000);
        idle(4);
        expect_b(0, 1, 0, 8'h0E); expect_b(0, 0, 0, 8'hAB); expect_b(0, 0, 1, 8'hCD);
        compare("data");
        check("data_done", done_cnt, 1);
        check("data_len", 32'(last_len), 3);
        check("data_done_with_eop", 32'(done_eop), 1);
        check("data_hdr_err", hdr_cnt, 0);
        clr();

        // Control packet, then zero-length data packet
        send_hdr(); send(9'h100); send(9'h15A); send(9'h100); send(9'h100); send(9'h000);
        idle(4);
        expect_b(1, 1, 0, 8'h5A); expect_b(1, 0, 0, 8'h00); expect_b(1, 0, 1, 8'h00);
        compare("ctrl");
        check("ctrl_status", 32'(mo_status), 32'h5A);
        check("ctrl_len", 32'(last_len), 3);
        clr();
        send_hdr(); send(9'h1FF); send(9'h000);
        idle(4);
        compare("zero");
        check("zero_done", done_cnt, 1);
        check("zero_len", 32'(last_len), 0);
        check("zero_no_eop", 32'(done_eop), 0);
        clr();

        // Header errors
        send(9'h10A); send(9'h101); send(9'h102); send(9'h107);
        idle(3);
        check("hdr_short_err", hdr_cnt, 1);
        clr();
        send(9'h10A); send(9'h101); send_hdr(); send(9'h1FF); send(9'h111); send(9'h000);
        idle(4);
        expect_b(0, 1, 1, 8'h11);
        compare("hdr_restart");
        check("hdr_restart_err", hdr_cnt, 1);
        check("hdr_restart_len", 32'(last_len), 1);
        clr();
        send_hdr(); send(9'h155); send(9'h111); send(9'h000);
        idle(3);
        check("bad_type_err", hdr_cnt, 1);
        check("bad_type_no_done", done_cnt, 0);
        compare("bad_type");
        clr();

        // Overlong payload on the MAX_LEN=4 instance
        use_small = 1'b1;
        send_hdr(); send(9'h1FF);
        for (int i = 1; i <= 6; i++) send({1'b1, 8'(i)});
        send(9'h000);
        idle(4);
        expect_b(0, 1, 0, 8'h01); expect_b(0, 0, 0, 8'h02);
        expect_b(0, 0, 0, 8'h03); expect_b(0, 0, 1, 8'h04);
        compare("overlong");
        check("overlong_len_err", len_cnt, 1);
        check("overlong_len", 32'(last_len), 4);
        check("overlong_done", done_cnt, 1);
        use_small = 1'b0;
        clr();

        // Backpressure: reference run, then the same packet with random out_ready
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 20; i++) expect_b(0, i == 0, i == 19, 8'(i * 37 + 5));
            if (pass == 1) begin
                bp_en = 1'b1; bp_chk = 1'b1; prev_stall = 1'b0;
            end
            send_hdr(); send(9'h1FF);
            for (int i = 0; i < 20; i++) send({1'b1, 8'(i * 37 + 5)});
            send(9'h000);
            for (int n = 0; n < 200 && got_q.size() < 20; n++) tick();
            bp_en = 1'b0; bp_chk = 1'b0; out_ready = 1'b1;
            idle(3);
            compare(pass == 0 ? "bp_ref" : "bp_run");
            check("bp_len", 32'(last_len), 20);
            clr();
        end

        // Reset mid-packet
        send_hdr(); send(9'h1FF);
        for (int i = 0; i < 5; i++) send({1'b1, 8'(8'h21 + i)});
        rst = 1'b0;
        #1;
        check_reset("mid_reset");
        check("mid_reset_no_done", done_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        clr();
        send_hdr(); send(9'h100); send(9'h177); send(9'h188); send(9'h000);
        idle(4);
        expect_b(1, 1, 0, 8'h77); expect_b(1, 0, 1, 8'h88);
        compare("post_reset");
        check("post_reset_status", 32'(mo_status), 32'h77);
        check("post_reset_len", 32'(last_len), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
